// File: rtl/ps2_key_rx_if.sv
// rtl/ps2_key_rx_if.sv - bus bundle between a host and the PS/2 key event receiver
//
// Purpose: groups the key-word input, event FIFO read side, status flags and
// held-key query port of ps2_key_rx into one interface.
// Signals:
//   ps2_key      host -> rx  11-bit key word {toggle, pressed, extended, code}
//   clr_state    host -> rx  synchronous clear of held state, FIFO and overflow
//   evt_rd       host -> rx  pop the head event
//   evt_valid    rx -> host  FIFO non-empty
//   evt_data     rx -> host  head event {pressed, extended, code}
//   evt_count    rx -> host  FIFO occupancy
//   overflow     rx -> host  sticky event-dropped flag
//   key_down_any rx -> host  at least one key held
//   query_code   host -> rx  {extended, code} held-state lookup address
//   query_down   rx -> host  held state of query_code (one cycle later)
interface ps2_key_rx_if;
    logic [10:0] ps2_key;
    logic        clr_state;
    logic        evt_rd;
    logic        evt_valid;
    logic [9:0]  evt_data;
    logic [6:0]  evt_count;
    logic        overflow;
    logic        key_down_any;
    logic [8:0]  query_code;
    logic        query_down;

    modport master (
        output ps2_key, clr_state, evt_rd, query_code,
        input  evt_valid, evt_data, evt_count, overflow, key_down_any, query_down
    );

    modport slave (
        input  ps2_key, clr_state, evt_rd, query_code,
        output evt_valid, evt_data, evt_count, overflow, key_down_any, query_down
    );
endinterface

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 key word receiver with event FIFO and held-key bitmap
//
// Purpose: watches the toggle bit of the hps_io key word, turns each toggle
// into a {pressed, extended, code} event, queues events in a show-ahead FIFO
// and tracks which keys are currently held.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      ps2_key_rx_if.slave (key word in, FIFO read side, status, query)
module ps2_key_rx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    ps2_key_rx_if.slave  bus
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);

    logic [10:0]   s1_q, s1_d;
    logic          t_prev_q, t_prev_d;
    logic          primed_q, primed_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [511:0]  held_q, held_d;
    logic [9:0]    held_count_q, held_count_d;
    logic          key_down_any_q, key_down_any_d;
    logic          query_down_q, query_down_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic          evt_det;
    logic [8:0]    evt_idx;
    logic          full, empty, pop, do_write, mem_we;

    always_comb begin
        s1_d     = bus.ps2_key;
        primed_d = 1'b1;
        // On the priming edge t_prev takes the toggle that s1 is loading now,
        // so a toggle already set at reset exit never looks like an event.
        t_prev_d = primed_q ? s1_q[10] : bus.ps2_key[10];

        evt_det  = primed_q && (s1_q[10] != t_prev_q);
        evt_idx  = s1_q[8:0];

        full     = (count_q == DEPTH_C);
        empty    = (count_q == 7'd0);
        pop      = bus.evt_rd && !empty;
        // A full FIFO still accepts a push when the same edge frees a slot.
        do_write = evt_det && (!full || pop);

        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        overflow_d     = overflow_q;
        held_d         = held_q;
        held_count_d   = held_count_q;
        mem_we         = 1'b0;

        if (bus.clr_state) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = 7'd0;
            overflow_d   = 1'b0;
            held_d       = '0;
            held_count_d = 10'd0;
        end else begin
            if (do_write) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + 7'(do_write) - 7'(pop);
            if (evt_det && full && !pop) begin
                overflow_d = 1'b1;
            end
            // The bitmap follows every event, including ones the FIFO drops.
            if (evt_det) begin
                if (s1_q[9]) begin
                    if (!held_q[evt_idx]) begin
                        held_count_d = held_count_q + 10'd1;
                    end
                    held_d[evt_idx] = 1'b1;
                end else begin
                    if (held_q[evt_idx]) begin
                        held_count_d = held_count_q - 10'd1;
                    end
                    held_d[evt_idx] = 1'b0;
                end
            end
        end

        key_down_any_d = (held_count_d != 10'd0);
        // Looks at the bitmap before this edge's update: no same-cycle bypass.
        query_down_d   = held_q[bus.query_code];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q           <= '0;
            t_prev_q       <= 1'b0;
            primed_q       <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= 7'd0;
            overflow_q     <= 1'b0;
            held_q         <= '0;
            held_count_q   <= 10'd0;
            key_down_any_q <= 1'b0;
            query_down_q   <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            t_prev_q       <= t_prev_d;
            primed_q       <= primed_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            held_q         <= held_d;
            held_count_q   <= held_count_d;
            key_down_any_q <= key_down_any_d;
            query_down_q   <= query_down_d;
        end
    end

    // Event storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= s1_q[9:0];
        end
    end

    assign bus.evt_valid    = !empty;
    assign bus.evt_data     = mem_q[rd_ptr_q];
    assign bus.evt_count    = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.key_down_any = key_down_any_q;
    assign bus.query_down   = query_down_q;

endmodule
